memory_game_fsm: RTL and testbench
==================================

# memory_game_fsm

Parametrised top-level game controller for the memory game. It sequences main menu, colour computation, a timed card preview, and two-click turns with pair comparison. It also handles the mismatch hold time, matched-card bookkeeping, move counting and win detection. It sits between the mouse/click decoding logic, the colour generator with its colour RAM, and the card/menu drawing pipeline.

## Interface
- `NUM_CARDS`, default 16: number of cards on the board; even, 4..64.
- `IDX_W`, default 6: card index width; must satisfy 2^IDX_W ≥ NUM_CARDS.
- `COLOR_W`, default 12: colour word width.
- `PREVIEW_TICKS`, default 120: `tick` pulses all cards stay face-up after computing.
- `MISMATCH_TICKS`, default 60: `tick` pulses a mismatched pair stays face-up.
- `MOVES_W`, default 10: move counter width.
- `clk` in 1: system clock (65 MHz pixel clock domain).
- `rst` in 1: synchronous reset, active-low.
- `tick` in 1: one-cycle frame pulse, used by the timers.
- `start_button_pressed` in 1: one-cycle pulse.
- `computing_colors_finished` in 1: level from the colour generator.
- `card_clicked` in 1: one-cycle pulse; `clicked_idx` is valid with it.
- `clicked_idx` in IDX_W: index of the clicked card.
- `color_rd_data` in COLOR_W: colour RAM data, valid 1 cycle after `color_rd_idx`.
- `color_rd_idx` out IDX_W: colour RAM read address.
- `draw_start_button`, `compute_colors`, `draw_cards` out 1: mode flags for the draw pipeline.
- `face_up` out NUM_CARDS: bit i set means card i is shown face-up.
- `matched` out NUM_CARDS: bit i set means card i is permanently matched.
- `move_count` out MOVES_W: completed turns, saturating.
- `game_won` out 1: high in the WON state.

## Operation
- States:
  - MENU: `draw_start_button`=1. A `start_button_pressed` pulse clears `matched`, `face_up` and `move_count`, then moves to COMPUTE.
  - COMPUTE: `compute_colors`=1 while waiting for `computing_colors_finished`, then PREVIEW.
  - PREVIEW: `face_up` is all-ones and the timer loads PREVIEW_TICKS. The timer decrements on `tick`. At 0 the FSM moves to FIRST and `face_up` becomes `matched`.
  - FIRST: a valid click stores idx A, sets `face_up[A]`, then moves to SECOND.
  - SECOND: a valid click with idx ≠ A stores idx B, sets `face_up[B]`, then moves to RD_A.
  - RD_A: drives `color_rd_idx`=A, then RD_B.
  - RD_B: captures colour A, drives `color_rd_idx`=B, then CMP.
  - CMP: captures colour B and increments `move_count` (saturating at all-ones).
    - Equal colours: set `matched[A]` and `matched[B]`. If `matched` becomes all-ones go to WON, else FIRST.
    - Unequal colours: load the timer with MISMATCH_TICKS and go to HOLD.
  - HOLD: wait for the timer to reach 0, then clear `face_up[A]` and `face_up[B]` and go to FIRST.
  - WON: `game_won`=1 and `face_up` is all-ones. `start_button_pressed` restarts exactly as from MENU.
- A click is valid only when `card_clicked`=1, `clicked_idx` < NUM_CARDS and `matched[clicked_idx]`=0.
- Invalid clicks, clicks outside FIRST/SECOND, and a repeat click on A are ignored with no state change.
- `draw_cards` is 1 in every state from PREVIEW onward. `compute_colors` is 1 only in COMPUTE. `draw_start_button` is 1 only in MENU.
- `start_button_pressed` outside MENU/WON is ignored.

## Timing
- All outputs are registered (next-state logic feeds output registers).
- Flags change 1 cycle after the state transition that causes them.
- Reset (`rst`=0 at a clk edge) forces state MENU, all outputs 0, timer 0, A/B registers 0.
  - `draw_start_button` rises on the first cycle after reset release.
  - Reset mid-turn or mid-hold aborts with no residual `face_up`.
- Turn latency: second valid click at cycle t gives the CMP decision at t+3. `matched`, `move_count` and the HOLD entry are visible at t+4.
- Timer value 0 (parameter = 0) leaves PREVIEW/HOLD on the next cycle without waiting for a `tick`.
- `tick` and a state transition in the same cycle: the tick only counts if the FSM is already in a timed state.
- Simultaneous `card_clicked` and `tick` in HOLD: the click is ignored.
- Colour RAM read latency is fixed at 1 cycle and is not handshaked.

## Structure
- Shared package `memory_game_pkg`: the state encoding localparams (4-bit) and the default NUM_CARDS/COLOR_W values, shared with the draw and colour modules.
- One sub-module, `tick_timer`: a down-counter with load value, `tick` enable and a `zero` flag, used for both preview and mismatch holds.
- Everything else lives in `memory_game_fsm`.

## Test plan
- Reset then start: after `rst` low→high, `draw_start_button`=1 and all other outputs 0. A start pulse puts `compute_colors`=1 the next cycle. `computing_colors_finished`=1 gives `face_up`=16'hFFFF, then all 0 after 120 ticks.
- Matching pair: colours [3]=[7]=12'hABC, click 3 then 7. At t+4, `matched`=16'h0088, `move_count`=1 and no HOLD.
- Mismatch: click 2 (12'h111) then 5 (12'h222). `face_up`=16'h0024 for 60 ticks, then 0, `move_count`=1.
- Ignored clicks: click 2 twice, click a matched card, click idx 20, and click during HOLD. State and `face_up` are unchanged after each.
- Win: solve 8 pairs. `game_won`=1 after the last CMP and `move_count`=8. A start pulse restarts with `matched`=0.
- Mid-turn reset: assert `rst`=0 during HOLD. On the next edge all outputs are 0 and the FSM is in MENU. Also run MISMATCH_TICKS=0: HOLD lasts exactly 1 cycle.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory game: state encoding and
// default board geometry used by the controller, draw and colour logic.
package memory_game_pkg;

    localparam int DEF_NUM_CARDS = 16;
    localparam int DEF_COLOR_W   = 12;

    localparam logic [3:0] ST_MENU    = 4'd0;
    localparam logic [3:0] ST_COMPUTE = 4'd1;
    localparam logic [3:0] ST_PREVIEW = 4'd2;
    localparam logic [3:0] ST_FIRST   = 4'd3;
    localparam logic [3:0] ST_SECOND  = 4'd4;
    localparam logic [3:0] ST_RD_A    = 4'd5;
    localparam logic [3:0] ST_RD_B    = 4'd6;
    localparam logic [3:0] ST_CMP     = 4'd7;
    localparam logic [3:0] ST_HOLD    = 4'd8;
    localparam logic [3:0] ST_WON     = 4'd9;

    typedef enum logic [3:0] {
        S_MENU    = ST_MENU,
        S_COMPUTE = ST_COMPUTE,
        S_PREVIEW = ST_PREVIEW,
        S_FIRST   = ST_FIRST,
        S_SECOND  = ST_SECOND,
        S_RD_A    = ST_RD_A,
        S_RD_B    = ST_RD_B,
        S_CMP     = ST_CMP,
        S_HOLD    = ST_HOLD,
        S_WON     = ST_WON
    } state_e;

endpackage

// File: rtl/memory_game_tick_timer.sv
// Frame-tick down-counter shared by the preview and mismatch holds.
// Load wins over a tick; the count stops at zero.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // count down on enabled ticks, reload on demand
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memory_game_fsm.sv
// Memory game controller: menu, colour compute, preview, two-click
// turns with pair compare, mismatch hold, move count and win detect.
module memory_game_fsm
    import memory_game_pkg::*;
#(
    parameter int NUM_CARDS      = DEF_NUM_CARDS,
    parameter int IDX_W          = 6,
    parameter int COLOR_W        = DEF_COLOR_W,
    parameter int PREVIEW_TICKS  = 120,
    parameter int MISMATCH_TICKS = 60,
    parameter int MOVES_W        = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start_button_pressed,
    input  logic                 computing_colors_finished,
    input  logic                 card_clicked,
    input  logic [IDX_W-1:0]     clicked_idx,
    input  logic [COLOR_W-1:0]   color_rd_data,
    output logic [IDX_W-1:0]     color_rd_idx,
    output logic                 draw_start_button,
    output logic                 compute_colors,
    output logic                 draw_cards,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [MOVES_W-1:0]   move_count,
    output logic                 game_won
);

    localparam int TMAX = (PREVIEW_TICKS > MISMATCH_TICKS) ?
                          PREVIEW_TICKS : MISMATCH_TICKS;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [NUM_CARDS-1:0] ONE = NUM_CARDS'(1);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_a_q, idx_b_q, rd_idx_q;
    logic [COLOR_W-1:0]   color_a_q;
    logic [NUM_CARDS-1:0] face_q, matched_q;
    logic [MOVES_W-1:0]   moves_q;
    logic                 dsb_q, cc_q, dc_q, won_q;

    logic [NUM_CARDS-1:0] oh_click, oh_a, oh_b, mat_next;
    logic                 click_ok, colors_eq;
    logic                 tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]        tmr_val;

    // click qualification, pair compare and timer control
    always_comb begin
        oh_click  = ONE << clicked_idx;
        oh_a      = ONE << idx_a_q;
        oh_b      = ONE << idx_b_q;
        mat_next  = matched_q | oh_a | oh_b;
        click_ok  = card_clicked
                 && ({1'b0, clicked_idx} < (IDX_W+1)'(NUM_CARDS))
                 && ((matched_q & oh_click) == '0);
        colors_eq = (color_rd_data == color_a_q);
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (state_q == S_COMPUTE && computing_colors_finished) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(PREVIEW_TICKS);
        end else if (state_q == S_CMP && !colors_eq) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(MISMATCH_TICKS);
        end
        tmr_en = tick && (state_q == S_PREVIEW || state_q == S_HOLD);
    end

    tick_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (tmr_en),
        .zero_o     (tmr_zero)
    );

    // game sequencing with registered mode flags and board state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_MENU;
            idx_a_q   <= '0;
            idx_b_q   <= '0;
            rd_idx_q  <= '0;
            color_a_q <= '0;
            face_q    <= '0;
            matched_q <= '0;
            moves_q   <= '0;
            dsb_q     <= 1'b0;
            cc_q      <= 1'b0;
            dc_q      <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            dsb_q <= (state_q == S_MENU);
            cc_q  <= (state_q == S_COMPUTE);
            dc_q  <= !(state_q == S_MENU || state_q == S_COMPUTE);
            won_q <= (state_q == S_WON);
            unique case (state_q)
                S_MENU, S_WON: begin
                    if (start_button_pressed) begin
                        matched_q <= '0;
                        face_q    <= '0;
                        moves_q   <= '0;
                        state_q   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (computing_colors_finished) begin
                        face_q  <= '1;
                        state_q <= S_PREVIEW;
                    end
                end
                S_PREVIEW: begin
                    if (tmr_zero) begin
                        face_q  <= matched_q;
                        state_q <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (click_ok) begin
                        idx_a_q <= clicked_idx;
                        face_q  <= face_q | oh_click;
                        state_q <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (click_ok && clicked_idx != idx_a_q) begin
                        idx_b_q  <= clicked_idx;
                        face_q   <= face_q | oh_click;
                        rd_idx_q <= idx_a_q;
                        state_q  <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    rd_idx_q <= idx_b_q;
                    state_q  <= S_RD_B;
                end
                S_RD_B: begin
                    color_a_q <= color_rd_data;
                    state_q   <= S_CMP;
                end
                S_CMP: begin
                    if (moves_q != '1) moves_q <= moves_q + MOVES_W'(1);
                    if (colors_eq) begin
                        matched_q <= mat_next;
                        if (&mat_next) begin
                            face_q  <= '1;
                            state_q <= S_WON;
                        end else begin
                            state_q <= S_FIRST;
                        end
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (tmr_zero) begin
                        face_q  <= face_q & ~(oh_a | oh_b);
                        state_q <= S_FIRST;
                    end
                end
                default: state_q <= S_MENU;
            endcase
        end
    end

    assign color_rd_idx      = rd_idx_q;
    assign draw_start_button = dsb_q;
    assign compute_colors    = cc_q;
    assign draw_cards        = dc_q;
    assign face_up           = face_q;
    assign matched           = matched_q;
    assign move_count        = moves_q;
    assign game_won          = won_q;

endmodule

// File: tb/tb_memory_game_fsm.sv
// Bench for memory_game_fsm: directed table, randomized game against a
// turn-level reference model, mid-hold reset and zero-length timers.
module tb_memory_game_fsm;

    logic        clk = 1'b0;
    logic        rst, rst2, tick, start, fin, clicked;
    logic [5:0]  cidx;
    logic [11:0] rdat, rdat2;
    logic [5:0]  ridx, ridx2;
    logic        dsb, cc, dc, won, dsb2, cc2, dc2, won2;
    logic [15:0] face, mat, face2, mat2;
    logic [9:0]  mv, mv2;

    logic [11:0] col [64];
    logic [5:0]  partner [16];

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rdat  <= col[ridx];
    always @(posedge clk) rdat2 <= col[ridx2];

    memory_game_fsm dut (
        .clk(clk), .rst(rst), .tick(tick),
        .start_button_pressed(start),
        .computing_colors_finished(fin),
        .card_clicked(clicked), .clicked_idx(cidx),
        .color_rd_data(rdat), .color_rd_idx(ridx),
        .draw_start_button(dsb), .compute_colors(cc),
        .draw_cards(dc), .face_up(face), .matched(mat),
        .move_count(mv), .game_won(won)
    );

    memory_game_fsm #(.PREVIEW_TICKS(0), .MISMATCH_TICKS(0)) dut2 (
        .clk(clk), .rst(rst2), .tick(tick),
        .start_button_pressed(start),
        .computing_colors_finished(fin),
        .card_clicked(clicked), .clicked_idx(cidx),
        .color_rd_data(rdat2), .color_rd_idx(ridx2),
        .draw_start_button(dsb2), .compute_colors(cc2),
        .draw_cards(dc2), .face_up(face2), .matched(mat2),
        .move_count(mv2), .game_won(won2)
    );

    typedef struct {
        logic        en;
        logic [5:0]  idx;
        int          w;
        logic [15:0] face;
        logic [15:0] mat;
        logic [9:0]  mv;
    } vec_t;

    vec_t vt [12];

    // turn-level reference model state
    logic [15:0] m_mat, m_face;
    int          m_moves;
    bit          m_have_a, m_won;
    logic [5:0]  m_a;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic click(input logic [5:0] i);
        clicked = 1'b1;
        cidx    = i;
        cyc();
        clicked = 1'b0;
    endtask

    // expected board after one click, from the game rules
    task automatic model_click(input logic [5:0] ci, output bit mism);
        bit valid;
        mism  = 0;
        valid = (ci < 16);
        if (valid) valid = !m_mat[ci[3:0]];
        if (valid) begin
            if (!m_have_a) begin
                m_a = ci;
                m_have_a = 1;
                m_face[ci[3:0]] = 1'b1;
            end else if (ci != m_a) begin
                m_have_a = 0;
                m_moves++;
                if (col[m_a] == col[ci]) begin
                    m_mat[m_a[3:0]] = 1'b1;
                    m_mat[ci[3:0]]  = 1'b1;
                    m_face = m_mat;
                    if (&m_mat) begin
                        m_won  = 1;
                        m_face = 16'hFFFF;
                    end
                end else begin
                    mism = 1;
                    m_face[m_a[3:0]] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) col[i] = '0;
        partner[3] = 7;  partner[7] = 3;
        partner[2] = 8;  partner[8] = 2;
        partner[5] = 9;  partner[9] = 5;
        partner[0] = 1;  partner[1] = 0;
        partner[4] = 6;  partner[6] = 4;
        partner[10] = 11; partner[11] = 10;
        partner[12] = 13; partner[13] = 12;
        partner[14] = 15; partner[15] = 14;
        col[3] = 12'hABC; col[7] = 12'hABC;
        col[2] = 12'h111; col[8] = 12'h111;
        col[5] = 12'h222; col[9] = 12'h222;
        col[0] = 12'h500; col[1] = 12'h500;
        col[4] = 12'h501; col[6] = 12'h501;
        col[10] = 12'h502; col[11] = 12'h502;
        col[12] = 12'h503; col[13] = 12'h503;
        col[14] = 12'h504; col[15] = 12'h504;

        vt[0]  = '{1'b1, 6'd3,  1,  16'h0008, 16'h0000, 10'd0};
        vt[1]  = '{1'b1, 6'd3,  1,  16'h0008, 16'h0000, 10'd0};
        vt[2]  = '{1'b1, 6'd20, 1,  16'h0008, 16'h0000, 10'd0};
        vt[3]  = '{1'b1, 6'd7,  3,  16'h0088, 16'h0088, 10'd1};
        vt[4]  = '{1'b1, 6'd7,  1,  16'h0088, 16'h0088, 10'd1};
        vt[5]  = '{1'b1, 6'd2,  1,  16'h008C, 16'h0088, 10'd1};
        vt[6]  = '{1'b1, 6'd5,  3,  16'h00AC, 16'h0088, 10'd2};
        vt[7]  = '{1'b1, 6'd0,  1,  16'h00AC, 16'h0088, 10'd2};
        vt[8]  = '{1'b0, 6'd0,  60, 16'h0088, 16'h0088, 10'd2};
        vt[9]  = '{1'b1, 6'd4,  1,  16'h0098, 16'h0088, 10'd2};
        vt[10] = '{1'b1, 6'd10, 63, 16'h0498, 16'h0088, 10'd3};
        vt[11] = '{1'b0, 6'd0,  0,  16'h0088, 16'h0088, 10'd3};

        rst = 0; rst2 = 0; tick = 1; start = 0; fin = 0;
        clicked = 0; cidx = '0;
        repeat (3) cyc();
        chk("rst_dsb", dsb, 0);
        chk("rst_cc", cc, 0);
        chk("rst_dc", dc, 0);
        chk("rst_face", face, 0);
        chk("rst_mat", mat, 0);
        chk("rst_mv", mv, 0);
        chk("rst_won", won, 0);

        rst = 1;
        cyc();
        chk("menu_dsb", dsb, 1);
        chk("menu_cc", cc, 0);
        chk("menu_dc", dc, 0);
        chk("menu_face", face, 0);
        chk("menu_won", won, 0);

        start = 1; cyc(); start = 0; cyc();
        chk("start_cc", cc, 1);
        chk("start_dsb", dsb, 0);

        fin = 1; cyc(); fin = 0;
        chk("prev_face0", face, 16'hFFFF);
        repeat (120) cyc();
        chk("prev_face120", face, 16'hFFFF);
        chk("prev_dc", dc, 1);
        cyc();
        chk("prev_end", face, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            clicked = vt[i].en;
            cidx    = vt[i].idx;
            cyc();
            clicked = 1'b0;
            repeat (vt[i].w) cyc();
            chk($sformatf("vec%0d_face", i), face, vt[i].face);
            chk($sformatf("vec%0d_mat", i), mat, vt[i].mat);
            chk($sformatf("vec%0d_mv", i), mv, vt[i].mv);
        end

        m_mat = 16'h0088; m_face = 16'h0088; m_moves = 3;
        m_have_a = 0; m_won = 0; m_a = '0;
        for (int it = 0; it < 400 && !m_won; it++) begin
            logic [5:0] ci;
            bit mism;
            if (m_have_a && $urandom_range(0, 1) == 1) ci = partner[m_a[3:0]];
            else ci = 6'($urandom_range(0, 19));
            model_click(ci, mism);
            click(ci);
            repeat (mism ? 67 : 5) cyc();
            chk($sformatf("rnd%0d_face", it), face, m_face);
            chk($sformatf("rnd%0d_mat", it), mat, m_mat);
            chk($sformatf("rnd%0d_mv", it), mv, 64'(m_moves));
            chk($sformatf("rnd%0d_won", it), won, 64'(m_won));
        end
        chk("game_won", won, 1);
        chk("won_face", face, 16'hFFFF);

        start = 1; cyc(); start = 0;
        chk("restart_mat", mat, 0);
        chk("restart_mv", mv, 0);
        cyc();
        chk("restart_won", won, 0);
        chk("restart_cc", cc, 1);

        fin = 1; repeat (125) cyc(); fin = 0;
        chk("rp_face", face, 0);
        click(6'd2); click(6'd5);
        repeat (10) cyc();
        chk("hold_face", face, 16'h0024);
        chk("hold_mv", mv, 1);
        rst = 0; cyc();
        chk("midrst_face", face, 0);
        chk("midrst_dc", dc, 0);
        chk("midrst_dsb", dsb, 0);
        chk("midrst_mv", mv, 0);
        chk("midrst_idx", ridx, 0);
        rst = 1; cyc();
        chk("midrst_menu", dsb, 1);
        chk("midrst_face2", face, 0);

        rst = 0; rst2 = 1; fin = 1;
        cyc();
        chk("z_dsb", dsb2, 1);
        start = 1; cyc(); start = 0; cyc();
        chk("z_prev", face2, 16'hFFFF);
        cyc();
        chk("z_prev_end", face2, 16'h0000);
        click(6'd2); click(6'd5);
        repeat (3) cyc();
        chk("z_hold", face2, 16'h0024);
        cyc();
        chk("z_hold_end", face2, 16'h0000);
        chk("z_mv", mv2, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
